// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, runs the imem req/ack handshake and feeds decode through an output slot backed by a 1-entry skid.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4,
  parameter int          MAX_WAIT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_instr_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_instr_pc,
  output logic        o_fetch_err
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;
  state_t          r_state;
  logic [31:0]     r_pc, r_addr, r_instr, r_ipc, r_skid_instr, r_skid_pc;
  logic            r_req, r_valid, r_err;
  logic [WW-1:0]   r_wait;
  logic            w_ack, w_consume, w_free;
  logic [31:0]     w_pc_next, w_redir_pc;
  assign w_ack       = r_req & i_imem_ack;
  assign w_consume   = r_valid & ~i_stall;
  assign w_free      = ~r_valid | ~i_stall;
  assign w_pc_next   = r_pc + 32'(PC_STEP);
  assign w_redir_pc  = {i_redirect_pc[31:2], 2'b00};
  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_instr_valid = r_valid;
  assign o_instruction = r_instr;
  assign o_instr_pc    = r_ipc;
  assign o_fetch_err   = r_err;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_req        <= 1'b0;
      r_valid      <= 1'b0;
      r_instr      <= 32'h0000_0013;
      r_ipc        <= 32'h0;
      r_skid_instr <= 32'h0;
      r_skid_pc    <= 32'h0;
      r_wait       <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_consume) r_valid <= 1'b0;
      if (w_ack) r_wait <= '0;
      else if (r_req && r_wait != WW'(MAX_WAIT)) r_wait <= r_wait + 1'b1;
      if (r_req && !i_imem_ack && r_wait == WW'(MAX_WAIT - 1)) r_err <= 1'b1;
      if (r_state != S_IDLE && i_redirect_valid) begin
        r_pc    <= w_redir_pc;
        r_valid <= 1'b0;
        r_req   <= 1'b1;
        if (|i_redirect_pc[1:0]) r_err <= 1'b1;
        // an unanswered request must still complete at its old address
        if (r_state != S_HOLD && !i_imem_ack) r_state <= S_DRAIN;
        else begin
          r_state <= S_REQ;
          r_addr  <= w_redir_pc;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
          S_REQ: if (w_ack) begin
            r_pc <= w_pc_next;
            if (w_free) begin
              r_instr <= i_imem_rdata;
              r_ipc   <= r_pc;
              r_valid <= 1'b1;
              r_addr  <= w_pc_next;
            end else begin
              r_skid_instr <= i_imem_rdata;
              r_skid_pc    <= r_pc;
              r_state      <= S_HOLD;
              r_req        <= 1'b0;
            end
          end
          S_HOLD: if (w_consume) begin
            r_instr <= r_skid_instr;
            r_ipc   <= r_skid_pc;
            r_valid <= 1'b1;
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
          S_DRAIN: if (w_ack) begin
            r_state <= S_REQ;
            r_addr  <= r_pc;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
